// File: rtl/shift65_tx_pkg.sv
// Shared definitions for the shift65 serializer: FSM states and width defaults.
package shift65_tx_pkg;

    // Default serialized word width and the beat-counter width derived from it.
    localparam int DEFAULT_WIDTH   = 65;
    localparam int DEFAULT_COUNT_W = $clog2(DEFAULT_WIDTH);

    // Two-state transmitter: waiting for a word, or shifting one out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } txState_e;

    // Beat-counter width for an arbitrary word width; never narrower than one bit.
    function automatic int countWidth(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift65_tx.sv
// Parallel-to-serial transmitter with valid/ready on both sides, zero-bubble
// back-to-back words, synchronous abort and asynchronous active-low reset.
module shift65_tx
    import shift65_tx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_last,
    output logic             busy
);

    localparam int CNT_W = countWidth(WIDTH);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    txState_e         state_q,  state_d;
    logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic inShift;
    logic lastBeat;
    logic loadWord;
    logic beatAccept;

    // Output decode: everything serial is gated by the SHIFT state so the
    // outputs read as zero in IDLE regardless of leftover register contents.
    always_comb begin
        inShift    = (state_q == SHIFT);
        lastBeat   = inShift && (count_q == '0);
        ser_valid  = inShift;
        busy       = inShift;
        ser_last   = lastBeat;
        ser_bit    = inShift && (MSB_FIRST ? shiftReg_q[WIDTH-1] : shiftReg_q[0]);
        in_ready   = !abort && (inShift ? (lastBeat && ser_ready) : 1'b1);
        loadWord   = in_valid && in_ready;
        beatAccept = inShift && ser_ready;
    end

    // Next-state logic: abort beats load, load beats a plain beat accept, so a
    // load on the final beat chains straight into the next word.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        count_d    = count_q;
        if (abort) begin
            state_d    = IDLE;
            shiftReg_d = '0;
            count_d    = '0;
        end else if (loadWord) begin
            state_d    = SHIFT;
            shiftReg_d = in_data;
            count_d    = LAST_COUNT;
        end else if (beatAccept) begin
            if (count_q != '0) begin
                shiftReg_d = MSB_FIRST ? (shiftReg_q << 1) : (shiftReg_q >> 1);
                count_d    = count_q - 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // State, shift register and beat counter; reset clears all without a clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_shift65_tx.sv
// Scoreboard bench for shift65_tx: an LSB-first and an MSB-first instance share
// the same stimulus; expected beats are queued per instance at load time and a
// monitor compares every presented beat against the queue head.
module tb_shift65_tx;

    typedef struct packed {
        logic b;
        logic last;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        abortIn;
    logic        inValid;
    logic        serReady;
    logic [64:0] inData;
    logic [1:0]  inReady;
    logic [1:0]  serValid;
    logic [1:0]  serBit;
    logic [1:0]  serLast;
    logic [1:0]  busy;

    beat_t q0[$];
    beat_t q1[$];

    int errors      = 0;
    int checks      = 0;
    int validCycles = 0;

    logic [64:0] wordOne  = 65'h1_0000_0000_0000_0001;
    logic [64:0] wordAlt  = 65'h0_AAAA_AAAA_AAAA_AAAA;
    logic [64:0] wordOnes = 65'h1_FFFF_FFFF_FFFF_FFFF;
    logic [64:0] wordMix  = 65'h0_1234_5678_9ABC_DEF0;
    logic [64:0] wordTop  = 65'h1_0000_0000_0000_0000;
    logic [64:0] wordJunk = 65'h1_5555_0000_FFFF_1234;

    shift65_tx #(.WIDTH(65), .MSB_FIRST(1'b0)) dutLsb (
        .clock     (clock),
        .reset     (reset),
        .abort     (abortIn),
        .in_valid  (inValid),
        .in_ready  (inReady[0]),
        .in_data   (inData),
        .ser_valid (serValid[0]),
        .ser_ready (serReady),
        .ser_bit   (serBit[0]),
        .ser_last  (serLast[0]),
        .busy      (busy[0])
    );

    shift65_tx #(.WIDTH(65), .MSB_FIRST(1'b1)) dutMsb (
        .clock     (clock),
        .reset     (reset),
        .abort     (abortIn),
        .in_valid  (inValid),
        .in_ready  (inReady[1]),
        .in_data   (inData),
        .ser_valid (serValid[1]),
        .ser_ready (serReady),
        .ser_bit   (serBit[1]),
        .ser_last  (serLast[1]),
        .busy      (busy[1])
    );

    // Free-running clock, period 10.
    initial forever #5 clock = ~clock;

    // Safety net in case the run never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [64:0] d, input logic r, input logic a);
        inValid  = v;
        inData   = d;
        serReady = r;
        abortIn  = a;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Queue the expected beat streams of one word for both bit orders.
    task automatic pushWord(input logic [64:0] w);
        beat_t e;
        for (int i = 0; i < 65; i++) begin
            e.b    = w[i];
            e.last = (i == 64);
            q0.push_back(e);
            e.b    = w[64-i];
            q1.push_back(e);
        end
    endtask

    task automatic flushQueues();
        q0.delete();
        q1.delete();
    endtask

    // Compare one instance's presented beat with its queue head; pop on accept.
    task automatic monitorDut(input int k);
        beat_t exp;
        int    qSize;
        qSize = (k == 0) ? q0.size() : q1.size();
        if (serValid[k]) begin
            if (qSize == 0) begin
                checkOutput($sformatf("unexpectedBeat%0d", k), int'(serValid[k]), 0);
            end else begin
                exp = (k == 0) ? q0[0] : q1[0];
                checkOutput($sformatf("serBit%0d", k), int'(serBit[k]), int'(exp.b));
                checkOutput($sformatf("serLast%0d", k), int'(serLast[k]), int'(exp.last));
                checkOutput($sformatf("busyShift%0d", k), int'(busy[k]), 1);
                if (serReady && !abortIn) begin
                    if (k == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
            end
        end else begin
            checkOutput($sformatf("busyIdle%0d", k), int'(busy[k]), 0);
            checkOutput($sformatf("lastIdle%0d", k), int'(serLast[k]), 0);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clock);
        if (serValid[0]) validCycles++;
        monitorDut(0);
        monitorDut(1);
    end

    task automatic checkIdleOutputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s_serValid%0d", tag, k), int'(serValid[k]), 0);
            checkOutput($sformatf("%s_serBit%0d", tag, k), int'(serBit[k]), 0);
            checkOutput($sformatf("%s_serLast%0d", tag, k), int'(serLast[k]), 0);
            checkOutput($sformatf("%s_busy%0d", tag, k), int'(busy[k]), 0);
            checkOutput($sformatf("%s_inReady%0d", tag, k), int'(inReady[k]), 1);
        end
    endtask

    // Directed stimulus sequence.
    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        #3;
        checkIdleOutputs("reset");
        tick();
        @(posedge clock);
        #2;
        reset = 1'b1;
        tick();

        // Single word, sink always ready: 65 beats, last flag only on beat 65.
        validCycles = 0;
        applyStimulus(1'b1, wordOne, 1'b1, 1'b0);
        pushWord(wordOne);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t1FirstBitLsb", int'(serBit[0]), 1);
        checkOutput("t1FirstBitMsb", int'(serBit[1]), 1);
        repeat (65) tick();
        checkOutput("t1ValidCycles", validCycles, 65);
        checkOutput("t1DoneValid", int'(serValid[0]), 0);
        checkOutput("t1DoneReady", int'(inReady[0]), 1);

        // Alternating stall/accept: 130 cycles of valid for one word.
        validCycles = 0;
        applyStimulus(1'b1, wordAlt, 1'b0, 1'b0);
        pushWord(wordAlt);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 130; i++) begin
            serReady = (i % 2 == 1);
            tick();
        end
        serReady = 1'b1;
        checkOutput("t2ValidCycles", validCycles, 130);
        checkOutput("t2DoneValid", int'(serValid[0]), 0);

        // Back-to-back words: second word offered on the first word's last beat.
        validCycles = 0;
        applyStimulus(1'b1, wordOne, 1'b1, 1'b0);
        pushWord(wordOne);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        repeat (64) tick();
        checkOutput("t3LastBeat", int'(serLast[0]), 1);
        applyStimulus(1'b1, wordOnes, 1'b1, 1'b0);
        pushWord(wordOnes);
        #1;
        checkOutput("t3ReadyLsb", int'(inReady[0]), 1);
        checkOutput("t3ReadyMsb", int'(inReady[1]), 1);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t3NoGapValid", int'(serValid[0]), 1);
        checkOutput("t3NoGapBit", int'(serBit[0]), 1);
        checkOutput("t3NoGapLast", int'(serLast[0]), 0);
        repeat (65) tick();
        checkOutput("t3ValidCycles", validCycles, 130);
        checkOutput("t3DoneValid", int'(serValid[0]), 0);

        // Abort at beat 20 with a word offered in the same cycle.
        applyStimulus(1'b1, wordAlt, 1'b1, 1'b0);
        pushWord(wordAlt);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        repeat (19) tick();
        applyStimulus(1'b1, wordJunk, 1'b1, 1'b1);
        #1;
        checkOutput("t4AbortReadyLsb", int'(inReady[0]), 0);
        checkOutput("t4AbortReadyMsb", int'(inReady[1]), 0);
        tick();
        flushQueues();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        #1;
        checkIdleOutputs("t4");
        repeat (3) tick();
        checkOutput("t4NotCaptured", int'(serValid[0]), 0);

        // Asynchronous reset between edges at beat 30, then a fresh word.
        applyStimulus(1'b1, wordOne, 1'b1, 1'b0);
        pushWord(wordOne);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        repeat (29) tick();
        checkOutput("t5BeforeReset", int'(serValid[0]), 1);
        #1;
        reset = 1'b0;
        #1;
        flushQueues();
        checkIdleOutputs("t5");
        @(posedge clock);
        #3;
        reset = 1'b1;
        validCycles = 0;
        applyStimulus(1'b1, wordMix, 1'b1, 1'b0);
        pushWord(wordMix);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t5RestartValid", int'(serValid[0]), 1);
        repeat (65) tick();
        checkOutput("t5ValidCycles", validCycles, 65);

        // Top bit only: MSB-first instance leads with a 1, LSB-first with a 0.
        applyStimulus(1'b1, wordTop, 1'b1, 1'b0);
        pushWord(wordTop);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t6FirstBitMsb", int'(serBit[1]), 1);
        checkOutput("t6FirstBitLsb", int'(serBit[0]), 0);
        repeat (65) tick();

        checkOutput("queueEmptyLsb", q0.size(), 0);
        checkOutput("queueEmptyMsb", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift65_tx.md
SHIFT65_TX -- requirements
Module: shift65_tx

Interface
REQ-001 Parameter WIDTH, default 65: serialized word width in bits.
REQ-002 Parameter MSB_FIRST, default 0: 0 sends data[0] first; 1 sends data[WIDTH-1] first.
REQ-003 clock  input  1: single clock; all state updates on its rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 abort  input  1: synchronous flush of the word in flight.
REQ-006 in_valid  input  1: parallel word offered.
REQ-007 in_ready  output  1: block can accept a parallel word this cycle.
REQ-008 in_data  input  WIDTH: parallel word; captured when in_valid and in_ready are both 1.
REQ-009 ser_valid  output  1: ser_bit is valid.
REQ-010 ser_ready  input  1: sink accepts ser_bit this cycle.
REQ-011 ser_bit  output  1: current serial bit.
REQ-012 ser_last  output  1: current bit is the final bit of the word.
REQ-013 busy  output  1: a word is in flight (state SHIFT).

Function
REQ-014 The block SHALL have two states, IDLE and SHIFT, plus a WIDTH-bit shift register and a beat counter of $clog2(WIDTH) bits.
REQ-015 IDLE: ser_valid=0, busy=0, in_ready=1; a load (in_valid and in_ready) SHALL capture in_data, set count=WIDTH-1 and enter SHIFT next cycle.
REQ-016 SHIFT: ser_valid=1, busy=1; ser_bit SHALL be shreg[0] if MSB_FIRST=0, else shreg[WIDTH-1]; ser_last=1 exactly when count==0.
REQ-017 Beat accept (ser_valid and ser_ready) with count!=0 SHALL shift shreg by one toward the output end, zero-filling, and decrement count.
REQ-018 Beat accept with count==0 SHALL return to IDLE unless a load occurs in the same cycle.
REQ-019 In SHIFT, in_ready SHALL equal ser_last and ser_ready (combinational), giving zero-bubble back-to-back words.
REQ-020 A load coincident with the last beat accept SHALL capture the new word, set count=WIDTH-1 and remain in SHIFT, so the new first bit follows the old last bit with no gap.
REQ-021 While ser_valid=1 and ser_ready=0, ser_bit, ser_last and count SHALL hold.
REQ-022 abort=1 SHALL force IDLE, count=0 and shreg=0 on the next edge.
REQ-023 abort SHALL take priority over beat accept and load.
REQ-024 A load offered in the same cycle as abort SHALL be ignored: in_ready is forced to 0 while abort=1.
REQ-025 Latency from load to first ser_valid SHALL be exactly 1 cycle.
REQ-026 A word with no stalls SHALL occupy exactly WIDTH cycles of ser_valid.

Reset
REQ-027 reset=0 SHALL immediately, without a clock edge, force state=IDLE, shreg=0 and count=0.
REQ-028 Output values during and after reset: ser_valid=0, ser_bit=0, ser_last=0, busy=0, in_ready=1.
REQ-029 Reset deassertion SHALL take effect on the first rising clock edge after reset rises.
REQ-030 Reset mid-word SHALL discard the word; no partial word resumes.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, SHIFT), the WIDTH default of 65, and the derived count-width constant.
REQ-032 No sub-module SHALL be used; shift register, counter and FSM reside in shift65_tx.

Verification
REQ-033 Reset, MSB_FIRST=0, ser_ready=1, load 65'h1_0000_0000_0000_0001 -> 65 beats: bit0=1, beats 2..64 =0, beat 65 =1 with ser_last=1 only there; in_ready=1 the next cycle.
REQ-034 ser_ready alternating 1,0 over a 65'h0_AAAA_AAAA_AAAA_AAAA word -> ser_bit stable across each stall; word completes in 130 cycles; the bit sequence is unchanged.
REQ-035 Second word 65'h1_FFFF_FFFF_FFFF_FFFF offered during the first word's last beat -> accepted that cycle; its bit0=1 appears in the very next cycle with no ser_valid gap.
REQ-036 abort=1 at beat 20 with in_valid=1 -> ser_valid=0 and busy=0 next cycle; the offered word is not captured; in_ready=1 afterward.
REQ-037 reset driven low between clock edges at beat 30 -> ser_valid, busy and ser_last drop to 0 before the next edge; after release, a fresh load restarts from beat 1.
REQ-038 MSB_FIRST=1, load 65'h1_0000_0000_0000_0000 -> first bit=1, remaining 64 bits=0.
